// File: rtl/hazard_sb.sv
// Hazard scoreboard for a 5-stage pipeline: tracks E/M/W producers, raises the
// D-stage stall and drives D/E forward selects, plus the HI/LO busy counter.
module hazard_sb #(
    parameter int RA_W     = 5,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [RA_W-1:0] d_rs,
    input  logic [RA_W-1:0] d_rt,
    input  logic [1:0]      d_tuse_rs,
    input  logic [1:0]      d_tuse_rt,
    input  logic [RA_W-1:0] d_dst,
    input  logic [1:0]      d_tnew,
    input  logic            d_md,
    input  logic            d_div,
    input  logic            d_hilo,
    output logic            stall,
    output logic [1:0]      fwd_rs_d,
    output logic [1:0]      fwd_rt_d,
    output logic [1:0]      fwd_rs_e,
    output logic [1:0]      fwd_rt_e,
    output logic            md_busy
);

    localparam logic [1:0] SEL_RF = 2'd0;
    localparam logic [1:0] SEL_E  = 2'd1;
    localparam logic [1:0] SEL_M  = 2'd2;
    localparam logic [1:0] SEL_W  = 2'd3;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [5:0] MULT_CNT = 6'(MULT_LAT);
    localparam logic [5:0] DIV_CNT  = 6'(DIV_LAT);

    logic [RA_W-1:0] e_dst, e_rs, e_rt, m_dst, w_dst;
    logic [1:0]      e_tnew, m_tnew, w_tnew;
    logic [5:0]      md_cnt;

    logic rs_stall, rt_stall, hilo_stall;

    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // A source only blocks D if its producer in E or M cannot deliver in time.
    function automatic logic src_stall(
        input logic [RA_W-1:0] s,
        input logic [1:0]      tuse,
        input logic [RA_W-1:0] ed,
        input logic [1:0]      et,
        input logic [RA_W-1:0] md,
        input logic [1:0]      mt
    );
        if (s == '0 || tuse == TUSE_NONE) return 1'b0;
        return ((ed == s) && (et > tuse)) || ((md == s) && (mt > tuse));
    endfunction

    function automatic logic [1:0] sel_d(
        input logic [RA_W-1:0] s,
        input logic [RA_W-1:0] ed,
        input logic [1:0]      et,
        input logic [RA_W-1:0] md,
        input logic [1:0]      mt,
        input logic [RA_W-1:0] wd,
        input logic [1:0]      wt
    );
        if (s == '0)                  return SEL_RF;
        if (ed == s && et == 2'd0)    return SEL_E;
        if (md == s && mt == 2'd0)    return SEL_M;
        if (wd == s && wt == 2'd0)    return SEL_W;
        return SEL_RF;
    endfunction

    function automatic logic [1:0] sel_e(
        input logic [RA_W-1:0] s,
        input logic [RA_W-1:0] md,
        input logic [1:0]      mt,
        input logic [RA_W-1:0] wd
    );
        if (s == '0)               return SEL_RF;
        if (md == s && mt == 2'd0) return SEL_M;
        if (wd == s)               return SEL_W;
        return SEL_RF;
    endfunction

    always_comb begin
        rs_stall   = src_stall(d_rs, d_tuse_rs, e_dst, e_tnew, m_dst, m_tnew);
        rt_stall   = src_stall(d_rt, d_tuse_rt, e_dst, e_tnew, m_dst, m_tnew);
        md_busy    = (md_cnt != 6'd0);
        hilo_stall = d_hilo && md_busy;
        stall      = rs_stall || rt_stall || hilo_stall;

        // D selects stay live during a stall so the held instruction sees progress.
        fwd_rs_d = sel_d(d_rs, e_dst, e_tnew, m_dst, m_tnew, w_dst, w_tnew);
        fwd_rt_d = sel_d(d_rt, e_dst, e_tnew, m_dst, m_tnew, w_dst, w_tnew);
        fwd_rs_e = sel_e(e_rs, m_dst, m_tnew, w_dst);
        fwd_rt_e = sel_e(e_rt, m_dst, m_tnew, w_dst);
    end

    // NOTE: state registers use non-blocking assignments so every stage shifts
    // from the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_dst  <= '0;
            e_tnew <= '0;
            e_rs   <= '0;
            e_rt   <= '0;
            m_dst  <= '0;
            m_tnew <= '0;
            w_dst  <= '0;
            w_tnew <= '0;
            md_cnt <= '0;
        end else begin
            if (stall) begin
                e_dst  <= '0;
                e_tnew <= '0;
                e_rs   <= '0;
                e_rt   <= '0;
            end else begin
                e_dst  <= d_dst;
                e_tnew <= d_tnew;
                e_rs   <= d_rs;
                e_rt   <= d_rt;
            end

            m_dst  <= e_dst;
            m_tnew <= tnew_dec(e_tnew);
            w_dst  <= m_dst;
            w_tnew <= tnew_dec(m_tnew);

            // A stalled md instruction has not issued, so it must not restart the count.
            if (d_md && !stall)
                md_cnt <= d_div ? DIV_CNT : MULT_CNT;
            else if (md_cnt != 6'd0)
                md_cnt <= md_cnt - 6'd1;
        end
    end

endmodule
